sync_gearbox_fifo: RTL and testbench

//  Single-clock lane-granular width-converting FIFO: accepts WR_LANES lanes/beat, emits RD_LANES lanes/beat, any ratio.

---
 rtl/gearbox_pkg.sv | 33 +++
 rtl/lane_last_detect.sv | 31 +++
 rtl/sync_gearbox_fifo.sv | 128 ++++++++++++
 tb/tb_sync_gearbox_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gearbox_pkg.sv
// Shared helpers for the lane-granular gearbox FIFO: modular pointer add and a
// lowest-set-bit finder used by the frame-end detector.
package gearbox_pkg;

  localparam int MAX_LANES = 1024;
  localparam int IDX_W     = $clog2(MAX_LANES);

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } first_one_t;

  // Explicit wrap so any depth works, not just powers of two; n must be <= depth.
  function automatic int unsigned ptr_add(input int unsigned ptr, input int unsigned n,
                                          input int unsigned depth);
    int unsigned s;
    s = ptr + n;
    return (s >= depth) ? (s - depth) : s;
  endfunction

  function automatic first_one_t first_one(input logic [MAX_LANES-1:0] mask);
    first_one_t r;
    r = '0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_last_detect.sv
// Finds the first frame-end tag in the read window and builds the keep mask
// covering lanes 0..k (or every lane when no tag is present).
module lane_last_detect
  import gearbox_pkg::*;
#(
  parameter  int N   = 160,
  localparam int K_W = $clog2(N)
) (
  input  logic [N-1:0]   tags,
  output logic [K_W-1:0] k,
  output logic           found,
  output logic [N-1:0]   keep
);

  if (N > MAX_LANES) begin : g_width_chk
    $error("lane_last_detect: N exceeds MAX_LANES");
  end

  first_one_t hit;

  always_comb begin
    hit   = first_one(MAX_LANES'(tags));
    found = hit.found;
    k     = K_W'(hit.idx);
    keep  = '0;
    for (int i = 0; i < N; i++) begin
      keep[i] = !hit.found || (IDX_W'(i) <= hit.idx);
    end
  end

endmodule

// File: rtl/sync_gearbox_fifo.sv
// Single-clock width-converting FIFO: WR_LANES lanes in per beat, RD_LANES lanes
// out per beat, with frame-end tagging that shortens the read beat at the tag.
module sync_gearbox_fifo
  import gearbox_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8,
  parameter  int WR_LANES    = 128,
  parameter  int RD_LANES    = 160,
  parameter  int DEPTH_LANES = 640,
  localparam int LVL_W       = $clog2(DEPTH_LANES + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [WR_LANES*DATA_WIDTH-1:0] wr_data,
  input  logic                           wr_last,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [RD_LANES*DATA_WIDTH-1:0] rd_data,
  output logic [RD_LANES-1:0]            rd_keep,
  output logic                           rd_last,
  output logic [LVL_W-1:0]               level
);

  localparam int PTR_W = $clog2(DEPTH_LANES);
  localparam int FR_W  = $clog2(DEPTH_LANES / WR_LANES + 1);
  localparam int K_W   = $clog2(RD_LANES);

  typedef logic [DATA_WIDTH-1:0] lane_t;

  if (DEPTH_LANES < WR_LANES + RD_LANES) begin : g_depth_chk
    $error("sync_gearbox_fifo: DEPTH_LANES must be >= WR_LANES + RD_LANES");
  end

  lane_t                  mem_q [DEPTH_LANES];
  logic [DEPTH_LANES-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       count_q, count_d, consumed;
  logic [FR_W-1:0]        frames_q, frames_d;

  lane_t                  win_data [RD_LANES];
  logic [RD_LANES-1:0]    win_tag, det_keep;
  logic [K_W-1:0]         det_k;
  logic                   det_found, space_ok, wr_fire, rd_fire;

  // Tags beyond the stored lanes are stale, so the window is masked by count.
  always_comb begin
    for (int i = 0; i < RD_LANES; i++) begin
      win_data[i] = mem_q[PTR_W'(ptr_add(32'(rd_ptr_q), 32'(i), DEPTH_LANES))];
      win_tag[i]  = tag_q[PTR_W'(ptr_add(32'(rd_ptr_q), 32'(i), DEPTH_LANES))]
                    && (32'(i) < 32'(count_q));
    end
  end

  lane_last_detect #(.N(RD_LANES)) u_detect (
    .tags  (win_tag),
    .k     (det_k),
    .found (det_found),
    .keep  (det_keep)
  );

  always_comb begin
    space_ok = (LVL_W'(DEPTH_LANES) - count_q) >= LVL_W'(WR_LANES);
    wr_ready = rst && space_ok;
    rd_valid = (count_q >= LVL_W'(RD_LANES)) || (frames_q != '0);
    rd_last  = rd_valid && det_found;
    rd_keep  = rd_valid ? det_keep : '0;
    rd_data  = '0;
    for (int i = 0; i < RD_LANES; i++) begin
      if (rd_keep[i]) rd_data[i*DATA_WIDTH +: DATA_WIDTH] = win_data[i];
    end
    level    = count_q;
    wr_fire  = wr_valid && wr_ready;
    rd_fire  = rd_valid && rd_ready;
    consumed = det_found ? (LVL_W'(det_k) + LVL_W'(1)) : LVL_W'(RD_LANES);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tag_d    = tag_q;
    count_d  = count_q;
    frames_d = frames_q;
    if (rd_fire) begin
      rd_ptr_d = PTR_W'(ptr_add(32'(rd_ptr_q), 32'(consumed), DEPTH_LANES));
      count_d  = count_d - consumed;
      if (det_found) begin
        tag_d[PTR_W'(ptr_add(32'(rd_ptr_q), 32'(det_k), DEPTH_LANES))] = 1'b0;
        frames_d = frames_d - FR_W'(1);
      end
    end
    if (wr_fire) begin
      wr_ptr_d = PTR_W'(ptr_add(32'(wr_ptr_q), WR_LANES, DEPTH_LANES));
      count_d  = count_d + LVL_W'(WR_LANES);
      frames_d = frames_d + FR_W'(wr_last);
      for (int i = 0; i < WR_LANES; i++) begin
        tag_d[PTR_W'(ptr_add(32'(wr_ptr_q), 32'(i), DEPTH_LANES))] = (i == WR_LANES - 1) && wr_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_q    <= '0;
      count_q  <= '0;
      frames_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tag_q    <= tag_d;
      count_q  <= count_d;
      frames_q <= frames_d;
    end
  end

  // Writing free lanes while reset is held is harmless: no pointer or count moves.
  always_ff @(posedge clk) begin
    if (wr_valid && space_ok) begin
      for (int i = 0; i < WR_LANES; i++) begin
        mem_q[PTR_W'(ptr_add(32'(wr_ptr_q), 32'(i), DEPTH_LANES))] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_sync_gearbox_fifo.sv
// Directed bench for sync_gearbox_fifo: a lane-level queue model predicts every
// read beat, which is checked whenever the model says a beat is on offer.
module tb_sync_gearbox_fifo;

  localparam int DW    = 8;
  localparam int WR    = 128;
  localparam int RD    = 160;
  localparam int DEPTH = 640;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid, wr_ready, wr_last;
  logic [WR*DW-1:0]  wr_data;
  logic              rd_valid, rd_ready, rd_last;
  logic [RD*DW-1:0]  rd_data;
  logic [RD-1:0]     rd_keep;
  logic [LVL_W-1:0]  level;

  int errors = 0;
  int checks = 0;

  byte unsigned mq[$];
  bit           tq[$];
  int           mframes = 0;

  sync_gearbox_fifo #(
    .DATA_WIDTH(DW), .WR_LANES(WR), .RD_LANES(RD), .DEPTH_LANES(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_keep(rd_keep),
    .rd_last(rd_last), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [RD*DW-1:0] obs, input logic [RD*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WR*DW-1:0] beat_idx(input int base);
    logic [WR*DW-1:0] b;
    for (int i = 0; i < WR; i++) b[i*DW +: DW] = 8'((base + i) % 256);
    return b;
  endfunction

  function automatic logic [WR*DW-1:0] beat_rand();
    logic [WR*DW-1:0] b;
    for (int i = 0; i < WR; i++) b[i*DW +: DW] = 8'($urandom_range(0, 255));
    return b;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_last"},  rd_last,  0);
    chk({tag, "_rd_keep"},  rd_keep,  0);
    chk({tag, "_rd_data"},  rd_data,  0);
    chk({tag, "_level"},    level,    0);
  endtask

  // One clock: check outputs against the model at the falling edge, drive the
  // inputs, then advance the model by whatever the handshakes should transfer.
  task automatic step(input bit wv, input logic [WR*DW-1:0] wd, input bit wl, input bit rr);
    int n, k, cons;
    bit ev, el, wfire, rfire;
    logic [RD*DW-1:0] ed;
    logic [RD-1:0]    ek;
    @(negedge clk);
    ev = (mq.size() >= RD) || (mframes != 0);
    n  = (mq.size() < RD) ? mq.size() : RD;
    k  = -1;
    for (int i = 0; i < n; i++) if (tq[i] && k < 0) k = i;
    el   = (k >= 0);
    cons = el ? k + 1 : RD;
    ed = '0;
    ek = '0;
    for (int i = 0; i < RD; i++) begin
      if (i < cons && i < n) begin
        ek[i] = 1'b1;
        ed[i*DW +: DW] = mq[i];
      end
    end
    chk("level", level, mq.size());
    chk("wr_ready", wr_ready, (DEPTH - mq.size()) >= WR);
    chk("rd_valid", rd_valid, ev);
    if (ev) begin
      chk("rd_data", rd_data, ed);
      chk("rd_keep", rd_keep, ek);
      chk("rd_last", rd_last, el);
    end
    wr_valid = wv;
    wr_data  = wd;
    wr_last  = wl;
    rd_ready = rr;
    wfire = wv && ((DEPTH - mq.size()) >= WR);
    rfire = rr && ev;
    @(posedge clk);
    if (rfire) begin
      for (int i = 0; i < cons; i++) begin
        void'(mq.pop_front());
        void'(tq.pop_front());
      end
      if (el) mframes--;
    end
    if (wfire) begin
      for (int i = 0; i < WR; i++) begin
        mq.push_back(wd[i*DW +: DW]);
        tq.push_back((i == WR - 1) && wl);
      end
      if (wl) mframes++;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 16; n++) begin
      if (mq.size() == 0) break;
      step(0, '0, 0, 1);
    end
    step(0, '0, 0, 0);
  endtask

  initial begin
    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_last  = 1'b0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;

    // Reset in the middle of a burst with data stored and a beat on offer.
    repeat (3) step(1, beat_rand(), 0, 0);
    @(negedge clk);
    rst      = 1'b0;
    wr_valid = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    mq.delete();
    tq.delete();
    mframes = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    wr_valid = 1'b0;
    step(0, '0, 0, 0);

    // Single short frame: offered below RD_LANES because of the tag.
    step(1, beat_rand(), 1, 0);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);

    // Two-beat frame: full beat then a 96-lane tail.
    step(1, beat_rand(), 0, 0);
    step(1, beat_rand(), 1, 0);
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);

    // Steady gearbox traffic crossing the storage wrap point.
    for (int b = 0; b < 5; b++) step(1, beat_idx(b * WR), 0, 1);
    drain();

    // Fill to capacity, hold a write against full, then free one read beat.
    repeat (5) step(1, beat_rand(), 0, 0);
    repeat (3) step(1, beat_rand(), 1, 0);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    drain();

    // Read stalled while writes keep arriving.
    step(1, beat_rand(), 0, 0);
    step(1, beat_rand(), 1, 0);
    step(1, beat_rand(), 0, 0);
    step(1, beat_rand(), 1, 0);
    step(0, '0, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
